// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: arbiter state and port-id encodings shared by the arbiter files
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker, the port not granted last wins a tie
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       grant_id
);
  always_comb begin
    grant_id = (&req) ? ~last : req[PORT_D];
    grant = (|req) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide DataMemory between the I-side and D-side caches
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int ADDR_WIDTH = 32,
  localparam int LINE_BITS = LINE_SIZE * 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic                  i_req_read,
  input  logic                  i_req_write,
  input  logic [LINE_BITS-1:0]  i_req_din,
  output logic                  i_req_ready,
  output logic                  i_resp_valid,
  input  logic                  d_req_valid,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_read,
  input  logic                  d_req_write,
  input  logic [LINE_BITS-1:0]  d_req_din,
  output logic                  d_req_ready,
  output logic                  d_resp_valid,
  output logic [LINE_BITS-1:0]  resp_dout,
  output logic                  mem_in_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LINE_BITS-1:0]  mem_din,
  input  logic                  mem_out_valid,
  input  logic [LINE_BITS-1:0]  mem_dout,
  input  logic                  mem_ready
);
  arb_state_t state, state_n;
  logic last_grant, owner, lat_write, lat_read, seen_busy;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [LINE_BITS-1:0] lat_din;
  logic [1:0] grant;
  logic grant_id, accept, done, busy, win_write, win_read;
  rr_pick2 u_pick (
    .req     ({d_req_valid, i_req_valid}),
    .last    (last_grant),
    .grant   (grant),
    .grant_id(grant_id)
  );
  always_comb begin
    accept = !reset && state == ARB_IDLE && mem_ready && |grant;
    done = state == ARB_WAIT && (lat_write ? mem_ready && seen_busy : mem_out_valid);
    busy = state != ARB_IDLE;
    win_write = grant_id ? d_req_write : i_req_write;
    win_read = (grant_id ? d_req_read : i_req_read) | ~win_write;
    state_n = state;
    state_n = accept ? ARB_ISSUE : state == ARB_ISSUE ? ARB_WAIT : done ? ARB_IDLE : state;
    i_req_ready = accept && grant_id == PORT_I;
    d_req_ready = accept && grant_id == PORT_D;
    i_resp_valid = done && owner == PORT_I;
    d_resp_valid = done && owner == PORT_D;
    resp_dout = (done && !lat_write) ? mem_dout : '0;
    mem_in_valid = state == ARB_ISSUE;
    mem_addr = busy ? lat_addr : '0;
    mem_read = busy && lat_read && !lat_write;
    mem_write = busy && lat_write;
    mem_din = busy ? lat_din : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PORT_I;
      owner <= PORT_I;
      lat_addr <= '0;
      lat_din <= '0;
      lat_write <= 1'b0;
      lat_read <= 1'b0;
      seen_busy <= 1'b0;
    end else if (accept) begin
      last_grant <= grant_id;
      owner <= grant_id;
      lat_addr <= grant_id ? d_req_addr : i_req_addr;
      lat_din <= grant_id ? d_req_din : i_req_din;
      lat_write <= win_write;
      lat_read <= win_read;
      seen_busy <= 1'b0;
    end else if (state == ARB_WAIT && lat_write) begin
      seen_busy <= done ? 1'b0 : seen_busy | ~mem_ready;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a DataMemory model
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 4;
  typedef struct {
    logic port;
    logic wr;
    logic [127:0] data;
  } exp_t;
  logic clk = 0, reset = 1;
  logic i_req_valid = 0, i_req_read = 0, i_req_write = 0;
  logic d_req_valid = 0, d_req_read = 0, d_req_write = 0;
  logic [31:0] i_req_addr = 0, d_req_addr = 0;
  logic [127:0] i_req_din = 0, d_req_din = 0;
  logic i_req_ready, d_req_ready, i_resp_valid, d_resp_valid;
  logic [127:0] resp_dout, mem_din;
  logic mem_in_valid, mem_read, mem_write, mem_ready;
  logic [31:0] mem_addr;
  logic mem_out_valid = 0;
  logic [127:0] mem_dout = 0;
  logic mem_busy = 0, mem_hold = 0, pend_wr = 0;
  logic [31:0] pend_addr = 0;
  logic [127:0] pend_din = 0;
  int mem_cnt = 0;
  logic [127:0] mem_arr[logic [31:0]];
  exp_t q[$];
  exp_t mon_e;
  int n_checks = 0, n_fail = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_read(i_req_read),
    .i_req_write(i_req_write), .i_req_din(i_req_din), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_read(d_req_read),
    .d_req_write(d_req_write), .d_req_din(d_req_din), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .resp_dout(resp_dout),
    .mem_in_valid(mem_in_valid), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_din(mem_din), .mem_out_valid(mem_out_valid),
    .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : {4{a}};
  endfunction

  assign mem_ready = !mem_busy && !mem_hold;

  always @(posedge clk) begin
    mem_out_valid <= 1'b0;
    if (!mem_busy) begin
      if (mem_in_valid) begin
        mem_busy <= 1'b1;
        mem_cnt <= MEM_LAT;
        pend_wr <= mem_write;
        pend_addr <= mem_addr;
        pend_din <= mem_din;
      end
    end else if (mem_cnt == 0) begin
      mem_busy <= 1'b0;
      if (pend_wr) mem_arr[pend_addr] = pend_din;
      else begin
        mem_out_valid <= 1'b1;
        mem_dout <= line_of(pend_addr);
      end
    end else mem_cnt <= mem_cnt - 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (i_resp_valid || d_resp_valid) begin
      check("resp_both_ports", {127'd0, i_resp_valid & d_resp_valid}, 0);
      if (q.size() == 0) check("resp_unexpected", {126'd0, i_resp_valid, d_resp_valid}, 0);
      else begin
        mon_e = q.pop_front();
        check("resp_port_d", {127'd0, d_resp_valid}, {127'd0, mon_e.port});
        check("resp_port_i", {127'd0, i_resp_valid}, {127'd0, !mon_e.port});
        if (!mon_e.wr) check("resp_dout", resp_dout, mon_e.data);
      end
    end
  end

  task automatic drive(input logic port, input logic v, input logic [31:0] a, input logic rd,
                       input logic wr, input logic [127:0] din);
    if (port) begin
      d_req_valid = v; d_req_addr = a; d_req_read = rd; d_req_write = wr; d_req_din = din;
    end else begin
      i_req_valid = v; i_req_addr = a; i_req_read = rd; i_req_write = wr; i_req_din = din;
    end
  endtask

  task automatic await_ready(input logic port, output int waited);
    waited = 0;
    while (waited < 60 && !(port ? d_req_ready : i_req_ready)) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("ready_seen", {127'd0, port ? d_req_ready : i_req_ready}, 1);
  endtask

  task automatic drain();
    int c = 0;
    while (q.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("drain_queue", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, c, d_at, i_at;
    logic saw_low, p;
    logic [31:0] addr_i, addr_d;
    mem_arr[32'h10] = {16{8'hA5}};
    drive(0, 1, 32'h10, 1, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_i_req_ready", {127'd0, i_req_ready}, 0);
    check("rst_mem_in_valid", {127'd0, mem_in_valid}, 0);
    check("rst_mem_addr", {96'd0, mem_addr}, 0);
    check("rst_mem_rw", {126'd0, mem_read, mem_write}, 0);
    check("rst_resp", {127'd0, i_resp_valid | d_resp_valid}, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 0;
    @(negedge clk);
    drive(0, 1, 32'h10, 1, 0, 0);
    #1;
    await_ready(0, w);
    check("rd_ready_latency", w, 0);
    q.push_back('{port: 1'b0, wr: 1'b0, data: {16{8'hA5}}});
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("rd_mem_in_valid", {127'd0, mem_in_valid}, 1);
    check("rd_mem_addr", {96'd0, mem_addr}, 32'h10);
    check("rd_mem_rw", {126'd0, mem_read, mem_write}, 2'b10);
    @(negedge clk);
    #1;
    check("rd_in_valid_one_cycle", {127'd0, mem_in_valid}, 0);
    check("rd_addr_held_wait", {96'd0, mem_addr}, 32'h10);
    drain();
    drive(0, 1, 32'h04, 1, 0, 0);
    drive(1, 1, 32'h08, 1, 0, 0);
    #1;
    check("tie_d_ready", {127'd0, d_req_ready}, 1);
    check("tie_i_ready", {127'd0, i_req_ready}, 0);
    q.push_back('{port: 1'b1, wr: 1'b0, data: line_of(32'h08)});
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    check("tie_addr1", {96'd0, mem_addr}, 32'h08);
    c = 0; d_at = -1; i_at = -1;
    while (i_at < 0 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
      if (d_resp_valid) d_at = c;
      if (i_req_ready) i_at = c;
    end
    check("tie_i_after_dresp", i_at - d_at, 1);
    q.push_back('{port: 1'b0, wr: 1'b0, data: line_of(32'h04)});
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("tie_addr2", {96'd0, mem_addr}, 32'h04);
    check("tie_issue2", {127'd0, mem_in_valid}, 1);
    drain();
    drive(1, 1, 32'h20, 0, 1, 128'h1234);
    #1;
    await_ready(1, w);
    q.push_back('{port: 1'b1, wr: 1'b1, data: 0});
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    check("wr_mem_rw", {126'd0, mem_read, mem_write}, 2'b01);
    check("wr_mem_din", mem_din, 128'h1234);
    check("wr_mem_addr", {96'd0, mem_addr}, 32'h20);
    c = 0; d_at = -1; saw_low = 0;
    while (d_at < 0 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
      if (!mem_ready) saw_low = 1;
      if (d_resp_valid) d_at = c;
    end
    check("wr_busy_before_resp", {127'd0, saw_low}, 1);
    check("wr_resp_seen", {127'd0, d_at >= 0}, 1);
    drain();
    drive(0, 1, 32'h20, 1, 0, 0);
    #1;
    await_ready(0, w);
    q.push_back('{port: 1'b0, wr: 1'b0, data: 128'h1234});
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    drain();
    drive(1, 1, 32'h30, 1, 1, 128'hBEEF);
    #1;
    await_ready(1, w);
    q.push_back('{port: 1'b1, wr: 1'b1, data: 0});
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    check("rdwr_is_write", {126'd0, mem_read, mem_write}, 2'b01);
    drain();
    drive(0, 1, 32'h44, 0, 0, 0);
    #1;
    await_ready(0, w);
    q.push_back('{port: 1'b0, wr: 1'b0, data: {4{32'h44}}});
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("noop_is_read", {126'd0, mem_read, mem_write}, 2'b10);
    drain();
    drive(1, 1, 32'h80, 1, 0, 0);
    #1;
    await_ready(1, w);
    q.push_back('{port: 1'b1, wr: 1'b0, data: line_of(32'h80)});
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    drain();
    addr_i = 32'h100;
    addr_d = 32'h200;
    drive(0, 1, addr_i, 1, 0, 0);
    drive(1, 1, addr_d, 1, 0, 0);
    #1;
    check("b2b_i_wins", {126'd0, i_req_ready, d_req_ready}, 2'b10);
    p = 0;
    for (int r = 0; r < 10; r++) begin
      q.push_back('{port: p, wr: 1'b0, data: line_of(p ? addr_d : addr_i)});
      @(negedge clk);
      if (p) addr_d += 4;
      else addr_i += 4;
      drive(p, 1, p ? addr_d : addr_i, 1, 0, 0);
      #1;
      c = 0;
      while (!(i_req_ready || d_req_ready) && c < 100) begin
        @(negedge clk);
        #1;
        c++;
      end
      check("rr_alt_d", {127'd0, d_req_ready}, {127'd0, !p});
      check("rr_alt_i", {127'd0, i_req_ready}, {127'd0, p});
      p = d_req_ready;
    end
    q.push_back('{port: p, wr: 1'b0, data: line_of(p ? addr_d : addr_i)});
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drain();
    mem_hold = 1;
    drive(1, 1, 32'h300, 1, 0, 0);
    repeat (2) begin
      #1;
      check("drop_no_ready", {127'd0, d_req_ready}, 0);
      @(negedge clk);
    end
    drive(1, 0, 0, 0, 0, 0);
    mem_hold = 0;
    repeat (3) begin
      #1;
      check("drop_no_issue", {126'd0, d_req_ready, mem_in_valid}, 0);
      @(negedge clk);
    end
    mem_hold = 1;
    drive(0, 1, 32'h60, 1, 0, 0);
    repeat (3) begin
      #1;
      check("blk_no_ready", {127'd0, i_req_ready}, 0);
      @(negedge clk);
    end
    mem_hold = 0;
    #1;
    check("blk_ready_on_release", {127'd0, i_req_ready}, 1);
    q.push_back('{port: 1'b0, wr: 1'b0, data: line_of(32'h60)});
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("blk_mem_addr", {96'd0, mem_addr}, 32'h60);
    drain();
    drive(0, 1, 32'h50, 1, 0, 0);
    #1;
    await_ready(0, w);
    q.push_back('{port: 1'b0, wr: 1'b0, data: line_of(32'h50)});
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("mid_wait_read", {126'd0, mem_read, mem_in_valid}, 2'b10);
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    check("arst_mem_addr", {96'd0, mem_addr}, 0);
    check("arst_mem_rw", {125'd0, mem_read, mem_write, mem_in_valid}, 0);
    check("arst_resp", {127'd0, i_resp_valid | d_resp_valid}, 0);
    q.delete();
    #2;
    reset = 0;
    c = 0;
    while (!mem_out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("arst_mem_out_seen", {127'd0, mem_out_valid}, 1);
    check("arst_resp_ignored", {127'd0, i_resp_valid}, 0);
    @(negedge clk);
    drive(1, 1, 32'h70, 1, 0, 0);
    #1;
    await_ready(1, w);
    q.push_back('{port: 1'b1, wr: 1'b0, data: line_of(32'h70)});
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
